addsub_accumulator: RTL and testbench
=====================================

Name: addsub_accumulator

Overview:
- Sequential front end that feeds the 4-bit carry-lookahead `adder` (ports s, ovf, a, b, cin) and consumes its result.
- Accepts one command at a time over a valid/ready handshake: ADD, SUB, LOAD or CLR against a 4-bit two's-complement accumulator.
- Drives the adder's a, b and cin operands, registers s and ovf into the accumulator, and presents each result on a valid/ready output port.
- Maintains a sticky overflow flag for software polling.

Parameters:
- SAT_EN, 0: 1 = saturate the accumulator on signed overflow; 0 = wrap modulo 16.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  command present
- in_ready  output  1  block can accept a command
- in_op  input  2  00 ADD, 01 SUB, 10 LOAD, 11 CLR
- in_data  input  4  signed operand
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_data  output  4  accumulator value after the command
- out_ovf  output  1  signed overflow of this command
- ovf_sticky  output  1  OR of out_ovf since last CLR or reset
- acc  output  4  live accumulator value

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high. rst high at an edge forces state IDLE, acc=0, out_data=0, out_ovf=0, out_valid=0, ovf_sticky=0 and drops any captured command.
  - in_ready is 1 in the first cycle after reset.
  - rst mid-operation (EXEC or HOLD) aborts the command without updating acc.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, register op_q and data_q, then go to EXEC. in_data and in_op are sampled only at the handshake edge.
  - EXEC: in_ready=0. Adder inputs are driven from op_q/data_q. At the end of the cycle, register the result into acc/out_data/out_ovf, set out_valid=1 and go to HOLD.
  - HOLD: out_valid=1, in_ready=0, outputs stable. On out_ready go to IDLE, with out_valid=0 from the next cycle.
- Latency and throughput:
  - Command accepted at edge N. out_valid is visible after edge N+1.
  - With out_ready tied high, in_ready returns after edge N+2, so throughput is one command per 3 cycles.
- Adder drive:
  - ADD: a=acc, b=data_q, cin=0.
  - SUB: a=acc, b=~data_q, cin=1.
  - LOAD and CLR bypass the adder.
- Result rules:
  - ADD/SUB without overflow: acc=s, out_ovf=0.
  - ADD/SUB with overflow: out_ovf=1.
    - SAT_EN=0: acc=s.
    - SAT_EN=1: acc=4'b0111 when the pre-op acc[3]=0, else 4'b1000.
  - LOAD: acc=data_q, out_ovf=0, ovf_sticky unchanged.
  - CLR: acc=0, out_ovf=0, ovf_sticky cleared to 0.
- ovf_sticky is set at the EXEC→HOLD edge when out_ovf=1.
- Boundaries:
  - SUB of 4'b1000 from 0 overflows, giving 1000 wrapped, or 0111 when saturating.
  - in_valid held while in_ready=0 is ignored and not queued; the upstream block keeps it asserted.
  - out_ready asserted while out_valid=0 has no effect.
  - acc is an output at all times, updated only at the EXEC edge.

Test Plan:
- Reset then LOAD 0111, ADD 0001 with SAT_EN=0 -> out_data=1000, out_ovf=1, ovf_sticky=1; out_valid exactly 1 cycle after the accept edge.
- Same sequence with SAT_EN=1 -> out_data=0111, out_ovf=1; acc stays 0111.
- LOAD 0011, SUB 0101 -> 1110, ovf=0. Then LOAD 1000, SUB 0001 -> 0111 with ovf=1 (SAT_EN=0) or 1000 (SAT_EN=1).
- Backpressure: hold out_ready=0 for 5 cycles after a result -> out_data/out_valid stable, in_ready=0, a concurrent in_valid is not accepted. Raise out_ready -> in_ready=1 on the next cycle.
- After an overflow, CLR -> acc=0, ovf_sticky=0. ADD 1111 + LOAD... sequence LOAD 1101, ADD 1000 -> 0101, ovf=1.
- Assert rst during EXEC following LOAD 0110 -> next cycle acc=0, out_valid=0, in_ready=1, no result emitted.

Source files
------------

// File: rtl/addsub_accumulator.sv
// Handshaked ADD/SUB/LOAD/CLR front end around a 4-bit carry-lookahead adder.
// Keeps a signed 4-bit accumulator and a sticky overflow flag.

module adder (
    output logic [3:0] s,
    output logic       ovf,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        s    = p ^ c[3:0];
        // Signed overflow: carry into the sign bit differs from carry out of it.
        ovf  = c[4] ^ c[3];
    end
endmodule

// state | meaning
// IDLE  | in_ready=1, waiting for a command
// EXEC  | adder driven from captured command, result registered at end of cycle
// HOLD  | out_valid=1, result held until out_ready
module addsub_accumulator #(
    parameter int SAT_EN = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_op,
    input  logic [3:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       out_ovf,
    output logic       ovf_sticky,
    output logic [3:0] acc
);
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [3:0] data_q, data_d;
    logic [3:0] acc_q, acc_d;
    logic       ovf_q, ovf_d;
    logic       sticky_q, sticky_d;

    logic [3:0] add_b;
    logic       add_cin;
    logic [3:0] add_s;
    logic       add_ovf;

    adder u_adder (
        .s   (add_s),
        .ovf (add_ovf),
        .a   (acc_q),
        .b   (add_b),
        .cin (add_cin)
    );

    always_comb begin
        add_cin = (op_q == OP_SUB);
        add_b   = add_cin ? ~data_q : data_q;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        sticky_d = sticky_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = in_op;
                    data_d  = in_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = HOLD;
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        ovf_d    = add_ovf;
                        sticky_d = sticky_q | add_ovf;
                        if (add_ovf && (SAT_EN != 0))
                            acc_d = acc_q[3] ? 4'b1000 : 4'b0111;
                        else
                            acc_d = add_s;
                    end
                    OP_LOAD: begin
                        acc_d = data_q;
                        ovf_d = 1'b0;
                    end
                    OP_CLR: begin
                        acc_d    = 4'b0000;
                        ovf_d    = 1'b0;
                        sticky_d = 1'b0;
                    end
                    default: ;
                endcase
            end
            HOLD: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= 2'b00;
            data_q   <= 4'b0000;
            acc_q    <= 4'b0000;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            data_q   <= data_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
        end
    end

    // The result register and accumulator only ever change together, so one flop set serves both.
    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == HOLD);
    assign out_data   = acc_q;
    assign out_ovf    = ovf_q;
    assign ovf_sticky = sticky_q;
    assign acc        = acc_q;
endmodule

// File: tb/tb_addsub_accumulator.sv
// Scoreboard bench: wrapping and saturating instances share stimulus, each checked
// against an integer-arithmetic reference model.

module tb_addsub_accumulator;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_op;
    logic [3:0] in_data;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, out_ovf_a, sticky_a;
    logic [3:0] out_data_a, acc_a;
    logic       in_ready_b, out_valid_b, out_ovf_b, sticky_b;
    logic [3:0] out_data_b, acc_b;

    int errors = 0;
    int checks = 0;

    logic       rand_mode = 1'b0;
    logic       forced_ready = 1'b1;

    logic [5:0] exp_a[$];
    logic [5:0] exp_b[$];
    logic [3:0] m_acc[2];
    logic       m_st[2];

    always #5 clk = ~clk;

    addsub_accumulator #(.SAT_EN(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_op(in_op), .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_ovf(out_ovf_a), .ovf_sticky(sticky_a), .acc(acc_a)
    );

    addsub_accumulator #(.SAT_EN(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_op(in_op), .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_ovf(out_ovf_b), .ovf_sticky(sticky_b), .acc(acc_b)
    );

    always @(posedge clk) begin
        #1;
        out_ready = rand_mode ? 1'($urandom_range(0, 1)) : forced_ready;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: signed integer arithmetic, range test for overflow, clamp or wrap.
    task automatic model_cmd(input logic [1:0] op, input logic [3:0] data);
        for (int i = 0; i < 2; i++) begin
            int a, d, r;
            logic ovf;
            a   = int'($signed(m_acc[i]));
            d   = int'($signed(data));
            ovf = 1'b0;
            case (op)
                2'b00:   r = a + d;
                2'b01:   r = a - d;
                2'b10:   r = d;
                default: begin r = 0; m_st[i] = 1'b0; end
            endcase
            if (op[1] == 1'b0 && (r > 7 || r < -8)) begin
                ovf = 1'b1;
                if (i == 1) r = (r > 7) ? 7 : -8;
            end
            m_acc[i] = 4'(r);
            if (ovf) m_st[i] = 1'b1;
            if (i == 0) exp_a.push_back({m_acc[i], ovf, m_st[i]});
            else        exp_b.push_back({m_acc[i], ovf, m_st[i]});
        end
    endtask

    always @(negedge clk) begin
        logic [5:0] e;
        if (!rst && out_valid_a && out_ready) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_a_unexpected: got result %0d expected none", out_data_a);
            end else begin
                e = exp_a.pop_front();
                chk("out_a_data", out_data_a, e[5:2]);
                chk("out_a_ovf", out_ovf_a, e[1]);
                chk("out_a_sticky", sticky_a, e[0]);
                chk("out_a_acc", acc_a, e[5:2]);
            end
        end
    end

    always @(negedge clk) begin
        logic [5:0] e;
        if (!rst && out_valid_b && out_ready) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_b_unexpected: got result %0d expected none", out_data_b);
            end else begin
                e = exp_b.pop_front();
                chk("out_b_data", out_data_b, e[5:2]);
                chk("out_b_ovf", out_ovf_b, e[1]);
                chk("out_b_sticky", sticky_b, e[0]);
                chk("out_b_acc", acc_b, e[5:2]);
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int n = 0;
        @(negedge clk);
        while (!in_ready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready_a;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] data);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        in_op    = op;
        in_data  = data;
        in_valid = 1'b1;
        @(posedge clk);
        model_cmd(op, data);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("lat_valid_exec", out_valid_a, 0);
        chk("lat_ready_exec", in_ready_a, 0);
        @(negedge clk);
        chk("lat_valid_hold_a", out_valid_a, 1);
        chk("lat_valid_hold_b", out_valid_b, 1);
    endtask

    initial begin
        bit ok;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_data   = 4'h0;
        out_ready = 1'b1;
        m_acc[0] = 4'h0; m_acc[1] = 4'h0;
        m_st[0]  = 1'b0; m_st[1]  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", in_ready_a, 1);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_acc", acc_a, 0);
        chk("rst_out_data", out_data_a, 0);
        chk("rst_out_ovf", out_ovf_a, 0);
        chk("rst_sticky", sticky_a, 0);

        send(2'b10, 4'b0111);
        send(2'b00, 4'b0001);
        chk("wrap_add_acc", acc_a, 4'b1000);
        chk("sat_add_acc", acc_b, 4'b0111);
        chk("wrap_add_sticky", sticky_a, 1);
        chk("sat_add_ovf", out_ovf_b, 1);

        send(2'b10, 4'b0011);
        send(2'b01, 4'b0101);
        chk("sub_nov_acc", acc_a, 4'b1110);
        chk("sub_nov_ovf", out_ovf_a, 0);
        send(2'b10, 4'b1000);
        send(2'b01, 4'b0001);
        chk("wrap_sub_acc", acc_a, 4'b0111);
        chk("sat_sub_acc", acc_b, 4'b1000);

        send(2'b11, 4'h0);
        chk("clr_acc", acc_a, 0);
        chk("clr_sticky", sticky_a, 0);
        send(2'b10, 4'b1101);
        send(2'b00, 4'b1000);
        chk("neg_wrap_acc", acc_a, 4'b0101);
        chk("neg_sat_acc", acc_b, 4'b1000);
        chk("neg_ovf", out_ovf_a, 1);

        send(2'b11, 4'h0);
        send(2'b01, 4'b1000);
        chk("zero_sub_min_wrap", acc_a, 4'b1000);
        chk("zero_sub_min_sat", acc_b, 4'b0111);

        // Backpressure: result held, concurrent command refused.
        @(negedge clk);
        forced_ready = 1'b0;
        @(posedge clk);
        send(2'b00, 4'b0010);
        in_op    = 2'b00;
        in_data  = 4'b0011;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid_a, 1);
            chk("bp_out_data", out_data_a, m_acc[0]);
            chk("bp_in_ready", in_ready_a, 0);
        end
        in_valid = 1'b0;
        forced_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 chk("bp_release_ready", in_ready_a, 1);

        // Reset during EXEC aborts the command.
        send(2'b10, 4'b0010);
        wait_ready(ok);
        if (ok) begin
            in_op    = 2'b10;
            in_data  = 4'b0110;
            in_valid = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            m_acc[0] = 4'h0; m_acc[1] = 4'h0;
            m_st[0]  = 1'b0; m_st[1]  = 1'b0;
            chk("abort_acc", acc_a, 0);
            chk("abort_out_valid", out_valid_a, 0);
            chk("abort_in_ready", in_ready_a, 1);
            chk("abort_sticky", sticky_b, 0);
        end

        rand_mode = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            if (op == 2'b11 && $urandom_range(0, 2) != 0) op = 2'b00;
            send(op, 4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        rand_mode = 1'b0;
        forced_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("drain_a", exp_a.size(), 0);
        chk("drain_b", exp_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
